// File: rtl/pg_seq_sum.sv
// Sequential carry resolver: consumes registered P/G vectors and resolves the carry
// chain CHUNK bits per clock, returning sum, carry-out and signed overflow.
module pg_seq_sum #(
    parameter int N     = 8,
    parameter int CHUNK = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  P,
    input  logic [N-1:0]                  G,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  S,
    output logic                          cout,
    output logic                          ovf,
    output logic [$clog2(N/CHUNK):0]      busy_cycles
);
    localparam int NCH = N / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = $clog2(NCH) + 1;

    if (CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_chunk
        $error("pg_seq_sum: N must be an integer multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    p_q, g_q, s_q;
    logic            carry_q, cout_q, ovf_q;
    logic [IW-1:0]   idx_q;
    logic [BW-1:0]   busy_q;

    logic [CHUNK-1:0] sum_d;
    logic             carry_d;
    logic             c_top_d;
    int               base;

    // Ripple only across the current chunk; c_top_d ends up as the carry into the
    // chunk's top bit, which on the last chunk is the carry into bit N-1.
    always_comb begin
        base    = int'(idx_q) * CHUNK;
        carry_d = carry_q;
        c_top_d = carry_q;
        sum_d   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c_top_d  = carry_d;
            sum_d[i] = p_q[base + i] ^ carry_d;
            carry_d  = g_q[base + i] | (p_q[base + i] & carry_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            g_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    p_q     <= P;
                    g_q     <= G;
                    carry_q <= cin;
                    idx_q   <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    s_q[base +: CHUNK] <= sum_d;
                    carry_q            <= carry_d;
                    idx_q              <= idx_q + 1'b1;
                    if (idx_q == IW'(NCH - 1)) begin
                        cout_q  <= carry_d;
                        ovf_q   <= carry_d ^ c_top_d;
                        busy_q  <= BW'(NCH);
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign S           = s_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign busy_cycles = busy_q;
endmodule

// File: tb/tb_pg_seq_sum.sv
// Directed bench for pg_seq_sum (N=8, CHUNK=2): latency, carry chains, backpressure,
// input isolation after accept and asynchronous reset mid-operation.
module tb_pg_seq_sum;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] P = '0, G = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] S;
    logic       cout, ovf;
    logic [2:0] busy_cycles;

    int nchk = 0;
    int errs = 0;

    pg_seq_sum #(.N(8), .CHUNK(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .P(P), .G(G), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .cout(cout), .ovf(ovf), .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an operand set for exactly one accept edge (block must be idle).
    task automatic send(input logic [7:0] p, input logic [7:0] g, input logic c);
        @(negedge clk);
        P = p; G = g; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid rises, bounded.
    task automatic wait_result(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic expect_res(input string tag, input logic [7:0] s, input logic co, input logic ov);
        chk({tag, "_S"}, S, s);
        chk({tag, "_cout"}, cout, co);
        chk({tag, "_ovf"}, ovf, ov);
        chk({tag, "_busy"}, busy_cycles, 4);
    endtask

    // With out_ready high the next edge completes the handshake.
    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_ov_drop"}, out_valid, 0);
        chk({tag, "_ir_back"}, in_ready, 1);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy_cycles, 0);
        @(negedge clk) rst_n = 1'b1;

        // 0x5A + 0x3C = 0x96, signed overflow
        send(8'h66, 8'h18, 1'b0);
        chk("basic_busy_ir", in_ready, 0);
        wait_result("basic", 4);
        expect_res("basic", 8'h96, 1'b0, 1'b1);
        drain("basic");

        send(8'hFE, 8'h01, 1'b0);
        wait_result("ripple", 4);
        expect_res("ripple", 8'h00, 1'b1, 1'b0);
        drain("ripple");

        send(8'hFF, 8'h00, 1'b1);
        wait_result("cin_ff", 4);
        expect_res("cin_ff", 8'h00, 1'b1, 1'b0);
        drain("cin_ff");

        send(8'h00, 8'h00, 1'b1);
        wait_result("cin_00", 4);
        expect_res("cin_00", 8'h01, 1'b0, 1'b0);
        drain("cin_00");

        // Backpressure: result held, new operands refused while DONE
        out_ready = 1'b0;
        send(8'h66, 8'h18, 1'b0);
        wait_result("bp", 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            P = 8'hFF; G = 8'h00; cin = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_ov_hold", out_valid, 1);
            chk("bp_S_hold", S, 8'h96);
            chk("bp_ir_low", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("bp");
        @(posedge clk);
        #1 chk("bp_no_accept", in_ready, 1);

        // Inputs changing during BUSY must not affect the result
        send(8'h66, 8'h18, 1'b0);
        P = 8'hFF; G = 8'h00; cin = 1'b1;
        wait_result("isolate", 4);
        expect_res("isolate", 8'h96, 1'b0, 1'b1);
        drain("isolate");

        // Reset in the second BUSY cycle
        send(8'h66, 8'h18, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_S", S, 0);
        chk("mrst_cout", cout, 0);
        chk("mrst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("mrst_ir", in_ready, 1);
        send(8'hFE, 8'h01, 1'b0);
        wait_result("post_rst", 4);
        expect_res("post_rst", 8'h00, 1'b1, 1'b0);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
